if_prefetch: RTL
================

# if_prefetch

Parametrised instruction-fetch stage with a registered program counter, a fixed-latency instruction-memory request port and a DEPTH-entry prefetch queue feeding decode through a valid/ready handshake. Branch/jump redirects flush the queue and restart fetch at the new target. It sits between the instruction memory and the decode stage and replaces the combinational fetch path. Field extraction (opcode, register, low bits) is carried forward.

## Interface
- ADDR_W, 8, PC and instruction-memory address width
- INSTR_W, 8, instruction word width
- OPC_W, 3, opcode field width (MSBs of the instruction)
- RS_W, 2, register field width (directly below opcode)
- DEPTH, 4, prefetch queue entries (≥2)
- RESET_PC, 0, first fetch address after reset

- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  synchronous, active-low reset
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address, meaningful when imem_req=1
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after the request
- redirect  in  1  branch/jump taken: flush and refetch
- redirect_pc  in  ADDR_W  redirect target
- if_valid  out  1  queue head valid
- if_ready  in  1  decode accepts head
- if_instr  out  INSTR_W  head instruction
- if_pc  out  ADDR_W  address of head instruction
- if_pc_next  out  ADDR_W  if_pc+1 mod 2^ADDR_W (link/sequential value)
- opcode  out  OPC_W  if_instr[INSTR_W-1 -: OPC_W]
- rs  out  RS_W  if_instr[INSTR_W-OPC_W-1 -: RS_W]
- low_bits  out  INSTR_W-OPC_W  if_instr[INSTR_W-OPC_W-1:0]

## Operation
- State: fetch_pc (ADDR_W), pending (1 bit: request issued last cycle), queue of DEPTH entries {instr, pc}, occupancy count (0..DEPTH), read/write pointers.
- pop = if_valid & if_ready & ~redirect.
- Issue: imem_req = ~redirect & (count + pending − pop < DEPTH). On issue, imem_addr = fetch_pc, fetch_pc ← fetch_pc+1 (wraps 2^ADDR_W−1 → 0), pending ← 1; else pending ← 0.
- Response: when pending=1 and ~redirect, push {imem_rdata, pc of that request} into queue. Credit rule guarantees push never overflows; push and pop in same cycle leave count unchanged.
- Redirect (highest priority): at the edge, queue emptied (count ← 0, pointers reset), fetch_pc ← redirect_pc, pending ← 0; response arriving that cycle is discarded; no request issued that cycle; pop suppressed.
- if_valid = (count≠0); head fields driven from queue head; outputs are don't-care when if_valid=0 but must be stable while if_valid=1 and if_ready=0.
- Reset (reset_n=0 at an edge, including mid-operation): fetch_pc ← RESET_PC, pending ← 0, count ← 0, pointers ← 0; during reset imem_req=0, if_valid=0. A response arriving the cycle after reset deasserts is ignored (pending=0).

## Timing
- Reset released before edge E0: request RESET_PC in cycle 0, data captured at end of cycle 1, if_valid=1 in cycle 2.
- Steady state with if_ready=1: one instruction per cycle for any DEPTH≥2.
- Redirect in cycle R: R+1 request redirect_pc, R+3 if_valid with if_pc=redirect_pc (2-cycle bubble after redirect cycle).
- if_ready held low: queue fills to DEPTH, then imem_req=0; each pop re-enables one request in the same cycle.
- if_ready is used combinationally only for issue credit; no combinational path from if_ready to if_valid or data outputs.

## Test plan
- Reset/startup: RESET_PC=0x10, if_ready=1, imem returns addr^0xA5 -> if_valid first high in cycle 2, if_pc sequence 0x10,0x11,0x12… one per cycle, if_instr matches, opcode/rs/low_bits slices correct.
- Backpressure: if_ready=0 for 10 cycles from cycle 2 -> count reaches DEPTH=4, imem_req=0 after 4 outstanding, head held stable; release -> in-order 0x10..0x13 then continuing, no loss or duplication.
- Redirect: redirect=1, redirect_pc=0x40 in cycle 6 with queue nonempty and pending=1 -> cycle 7 imem_addr=0x40, cycle 9 if_pc=0x40, no stale instruction ever presented.
- Wrap-around: RESET_PC=0xFE -> fetched pcs 0xFE,0xFF,0x00,0x01; if_pc_next for 0xFF is 0x00.
- Simultaneous events: redirect concurrent with if_ready=1 and full queue -> no pop counted, queue empty next cycle; redirect on two consecutive cycles -> second target wins, first never fetched.
- Reset mid-operation: reset_n=0 for one edge with queue full and pending=1 -> if_valid=0, imem_req=0 during reset; after release, fetch restarts at RESET_PC with 2-cycle latency.

Source files
------------

// File: rtl/if_prefetch.sv
// Instruction-fetch stage: registered PC, one-cycle-latency imem request port and
// a DEPTH-entry prefetch queue feeding decode through a valid/ready handshake.
module if_prefetch #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 8,
  parameter int                OPC_W    = 3,
  parameter int                RS_W     = 2,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [INSTR_W-1:0]       if_instr,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [ADDR_W-1:0]        if_pc_next,
  output logic [OPC_W-1:0]         opcode,
  output logic [RS_W-1:0]          rs,
  output logic [INSTR_W-OPC_W-1:0] low_bits
);

  // Handshake: decode takes the head on a cycle where if_valid && if_ready are
  // both high; if_valid and the head fields never depend on if_ready.

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int LAST_I  = DEPTH - 1;
  localparam logic [PTR_W-1:0] LAST_PTR = LAST_I[PTR_W-1:0];
  localparam logic [CNT_W:0]   DEPTH_C  = DEPTH[CNT_W:0];

  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  req_pc;
  logic               pending;
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic               pop;
  logic               push;
  logic               issue;
  logic [CNT_W:0]     credit_use;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) ptr_inc = '0;
    else               ptr_inc = p + PTR_W'(1);
  endfunction

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign if_valid = reset_n & (count != '0);
  assign pop      = if_valid & if_ready & ~redirect;
  assign push     = pending & ~redirect;

  // Credit counts queued entries plus the response still in flight, so a
  // request is only issued when its data is guaranteed a free slot.
  always_comb begin
    credit_use = {1'b0, count} + {{CNT_W{1'b0}}, pending} - {{CNT_W{1'b0}}, pop};
  end

  assign issue     = reset_n & ~redirect & (credit_use < DEPTH_C);
  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      // Flush everything; the response landing this cycle is dropped.
      fetch_pc <= redirect_pc;
      pending  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        req_pc   <= fetch_pc;
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries no reset; entries are only read while count != 0.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= req_pc;
    end
  end

  assign if_instr   = instr_q[rd_ptr];
  assign if_pc      = pc_q[rd_ptr];
  assign if_pc_next = if_pc + ADDR_W'(1);
  assign opcode     = if_instr[INSTR_W-1 -: OPC_W];
  assign rs         = if_instr[INSTR_W-OPC_W-1 -: RS_W];
  assign low_bits   = if_instr[INSTR_W-OPC_W-1:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    (push && !pop) |-> (count < DEPTH_C[CNT_W-1:0]));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    pop |-> (count != '0));

  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    ({1'b0, count} + {{CNT_W{1'b0}}, pending}) <= DEPTH_C);

endmodule
